vga_sync_decoder: RTL
=====================

Name: vga_sync_decoder

Overview:
- Sink-side counterpart of the VGA timing generator: consumes an hsync/vsync stream plus a pixel-clock enable and recovers pixel coordinates.
- Checks line and frame lengths against the nominal 640x480@60 timing, and declares lock after consecutive clean frames.
- Used as the receiving end in loopback benches and as the front end of frame-capture/pixel-checker logic.

Parameters:
- H_TOTAL, 800, pixels per line
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch
- H_ACTIVE, 640, visible pixels per line
- V_TOTAL, 525, lines per frame
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch
- V_ACTIVE, 480, visible lines
- LOCK_FRAMES, 2, consecutive error-free frames required for lock (1..15)
- SYNC_ACTIVE_LOW, 1, 1 = syncs asserted low, 0 = asserted high

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- pix_en  in  1  pixel enable; all sampling and counting advance only when high
- hsync  in  1  horizontal sync, polarity per SYNC_ACTIVE_LOW
- vsync  in  1  vertical sync, same polarity
- x  out  10  column within active area, 0..H_ACTIVE-1; holds last value outside it
- y  out  10  row within active area, 0..V_ACTIVE-1; holds last value outside it
- active  out  1  high while locked and (x,y) is inside the visible window
- frame_start  out  1  one-clk pulse on each detected frame start
- line_err  out  1  one-clk pulse when a measured line length != H_TOTAL
- frame_err  out  1  one-clk pulse when a measured frame length != V_TOTAL
- locked  out  1  high in the LOCKED state

Behaviour:
- Reset (async, active-high): counters, x, y, all pulses, active and locked go to 0; FSM goes to SEARCH; previous-sample regs go to the deasserted level.
- Sync decode:
  - hs = hsync XOR SYNC_ACTIVE_LOW; vs likewise.
  - Both are registered on pix_en cycles.
  - hsync leading edge (HLE) = hs high on this pix_en sample and low on the previous one.
- Horizontal counter hcnt (10b):
  - Set to 0 on HLE; otherwise increments on pix_en.
  - Saturates at 1023; never wraps.
- Line check: on HLE, if a previous HLE exists and hcnt+1 != H_TOTAL, pulse line_err.
- Frame start (FS) = HLE with vs sampled high and vs low at the prior HLE.
- Vertical counter vcnt (10b):
  - Set to 0 on FS; otherwise increments on each HLE.
  - Saturates at 1023.
- Frame check: on FS, if a previous FS exists and vcnt+1 != V_TOTAL, pulse frame_err.
- FS pulses frame_start.
- Coordinates:
  - x = hcnt-(H_SYNC+H_BP) when hcnt is in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE).
  - y = vcnt-(V_SYNC+V_BP) when vcnt is in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE).
  - All outputs are registered and lag the pix_en sample by 1 clk.
- FSM:
  - SEARCH: wait for the first FS, then go to TRAIN with good=0.
  - TRAIN: at each FS, increment good if no line_err/frame_err occurred in the finished frame, else set good=0. At good==LOCK_FRAMES go to LOCKED.
  - LOCKED: any line_err or frame_err returns to TRAIN with good=0.
  - Any state: no HLE for 2*H_TOTAL pix_en cycles returns to SEARCH and clears the "previous edge" flags.
- Edge cases:
  - An error on the same cycle as FS counts against the ending frame.
  - pix_en low freezes everything except reset.
  - Reset asserted mid-frame returns to SEARCH; the first full frame after reset is never checked.

Optional Feature:
- VGA_DECODER_STATS_EN defined: adds output err_count [15:0], a saturating count of line_err+frame_err pulses (both in one clk count 2). It is cleared by reset only.
- Undefined: the port and its logic are absent.

Decomposition:
- Package vga_timing_pkg holds:
  - the 640x480 timing constants (H_/V_ TOTAL, SYNC, BP, ACTIVE);
  - the FSM state enum (SEARCH, TRAIN, LOCKED).
- Natural sub-module: vga_sync_edge, which handles polarity normalise, the pix_en-gated sample register and leading-edge pulse. It is instantiated twice (hsync, vsync).

Test Plan:
- Nominal frames from the existing generator chain, pix_en every clk:
  - frame_start every 420000 clk;
  - locked rises at the 3rd FS (good reaches 2);
  - first active pixel has x=0,y=0 at hcnt=144,vcnt=35;
  - last active pixel has x=639,y=479.
- Inject one 799-pixel line after lock -> one line_err pulse; locked drops; relock after 2 further clean frames.
- Frame of 524 lines -> frame_err pulse at the next FS; good resets to 0.
- Stop hsync for 1600 pix_en cycles -> FSM enters SEARCH, locked=0; resume -> relock after FS+2 clean frames.
- pix_en asserted every 2nd clk -> same results as the first scenario at half rate; SYNC_ACTIVE_LOW=0 with inverted syncs -> identical coordinates.
- Assert reset mid-line and mid-frame -> all outputs 0 within the same clk edge (async); with VGA_DECODER_STATS_EN defined, err_count returns to 0 and then counts 3 after 3 injected errors.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants, counter widths and lock FSM states
// for the VGA sync decoder.
package vga_timing_pkg;

    localparam int unsigned VGA_H_TOTAL  = 800;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BP     = 48;
    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_V_TOTAL  = 525;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BP     = 33;
    localparam int unsigned VGA_V_ACTIVE = 480;

    localparam int unsigned VGA_CNT_W    = 10;
    localparam int unsigned VGA_GOOD_W   = 4;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        TRAIN  = 2'd1,
        LOCKED = 2'd2
    } sync_state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [VGA_CNT_W-1:0] sat_inc(input logic [VGA_CNT_W-1:0] v);
        return (v == '1) ? v : v + VGA_CNT_W'(1);
    endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// Sync polarity normalise, pix_en-gated sample register and leading-edge pulse.
module vga_sync_edge #(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic pix_en,
    input  logic sync_in,
    output logic level_c,
    output logic lead_c
);

    logic prev_q;

    assign level_c = sync_in ^ ACTIVE_LOW;
    assign lead_c  = pix_en & level_c & ~prev_q;

    // Previous normalised sample, reset to the deasserted level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q <= 1'b0;
        end else if (pix_en) begin
            prev_q <= level_c;
        end
    end

endmodule

// File: rtl/vga_sync_decoder.sv
// VGA sync decoder: recovers pixel coordinates from hsync/vsync, checks line
// and frame lengths and declares lock after LOCK_FRAMES clean frames.
// Optional build macro VGA_DECODER_STATS_EN adds the err_count output.
module vga_sync_decoder
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_TOTAL         = VGA_H_TOTAL,
    parameter int unsigned H_SYNC          = VGA_H_SYNC,
    parameter int unsigned H_BP            = VGA_H_BP,
    parameter int unsigned H_ACTIVE        = VGA_H_ACTIVE,
    parameter int unsigned V_TOTAL         = VGA_V_TOTAL,
    parameter int unsigned V_SYNC          = VGA_V_SYNC,
    parameter int unsigned V_BP            = VGA_V_BP,
    parameter int unsigned V_ACTIVE        = VGA_V_ACTIVE,
    parameter int unsigned LOCK_FRAMES     = 2,
    parameter int unsigned SYNC_ACTIVE_LOW = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pix_en,
    input  logic                 hsync,
    input  logic                 vsync,
    output logic [VGA_CNT_W-1:0] x,
    output logic [VGA_CNT_W-1:0] y,
    output logic                 active,
    output logic                 frame_start,
    output logic                 line_err,
    output logic                 frame_err,
`ifdef VGA_DECODER_STATS_EN
    output logic                 locked,
    output logic [15:0]          err_count
`else
    output logic                 locked
`endif
);

    localparam int unsigned CW      = VGA_CNT_W;
    localparam int unsigned CW1     = VGA_CNT_W + 1;
    localparam int unsigned GW      = VGA_GOOD_W;
    localparam int unsigned GAP_LIM = 2 * H_TOTAL;
    localparam int unsigned GAP_W   = $clog2(GAP_LIM + 1);
    localparam int unsigned H_OFF   = H_SYNC + H_BP;
    localparam int unsigned V_OFF   = V_SYNC + V_BP;

    logic              unused_hs_level_c;
    logic              unused_vs_lead_c;
    logic              hle_c;
    logic              vs_level_c;
    logic [CW-1:0]     hcnt_q;
    logic [CW-1:0]     vcnt_q;
    logic [CW-1:0]     hcnt_d;
    logic [CW-1:0]     vcnt_d;
    logic [GAP_W-1:0]  gap_q;
    logic              have_h_q;
    logic              have_v_q;
    logic              vs_at_hle_q;
    logic              fs_c;
    logic              line_err_c;
    logic              frame_err_c;
    logic              timeout_c;
    logic              in_h_c;
    logic              in_v_c;
    sync_state_e       state_q;
    logic [GW-1:0]     good_q;
    logic              bad_q;

    vga_sync_edge #(.ACTIVE_LOW(SYNC_ACTIVE_LOW != 0)) u_hs_edge (
        .clk     (clk),
        .reset   (reset),
        .pix_en  (pix_en),
        .sync_in (hsync),
        .level_c (unused_hs_level_c),
        .lead_c  (hle_c)
    );

    vga_sync_edge #(.ACTIVE_LOW(SYNC_ACTIVE_LOW != 0)) u_vs_edge (
        .clk     (clk),
        .reset   (reset),
        .pix_en  (pix_en),
        .sync_in (vsync),
        .level_c (vs_level_c),
        .lead_c  (unused_vs_lead_c)
    );

    // Per-sample events, next counter values and window decode.
    always_comb begin
        fs_c        = hle_c & vs_level_c & ~vs_at_hle_q;
        line_err_c  = hle_c & have_h_q & ((CW1'(hcnt_q) + CW1'(1)) != CW1'(H_TOTAL));
        frame_err_c = fs_c & have_v_q & ((CW1'(vcnt_q) + CW1'(1)) != CW1'(V_TOTAL));
        timeout_c   = pix_en & ~hle_c & (gap_q == GAP_W'(GAP_LIM - 1));
        hcnt_d      = hle_c ? '0 : sat_inc(hcnt_q);
        vcnt_d      = vcnt_q;
        if (fs_c) begin
            vcnt_d = '0;
        end else if (hle_c) begin
            vcnt_d = sat_inc(vcnt_q);
        end
        in_h_c = (hcnt_d >= CW'(H_OFF)) && (hcnt_d < CW'(H_OFF + H_ACTIVE));
        in_v_c = (vcnt_d >= CW'(V_OFF)) && (vcnt_d < CW'(V_OFF + V_ACTIVE));
    end

    // Position counters, hsync gap watchdog and previous-edge flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hcnt_q      <= '0;
            vcnt_q      <= '0;
            gap_q       <= '0;
            have_h_q    <= 1'b0;
            have_v_q    <= 1'b0;
            vs_at_hle_q <= 1'b0;
        end else if (pix_en) begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
            if (hle_c) begin
                gap_q       <= '0;
                have_h_q    <= 1'b1;
                vs_at_hle_q <= vs_level_c;
            end else if (gap_q != GAP_W'(GAP_LIM)) begin
                gap_q <= gap_q + GAP_W'(1);
            end
            if (fs_c) begin
                have_v_q <= 1'b1;
            end
            if (timeout_c) begin
                have_h_q <= 1'b0;
                have_v_q <= 1'b0;
            end
        end
    end

    // Lock FSM: SEARCH -> TRAIN -> LOCKED, watchdog drops back to SEARCH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= SEARCH;
            good_q  <= '0;
            bad_q   <= 1'b0;
            locked  <= 1'b0;
        end else if (pix_en) begin
            if (timeout_c) begin
                state_q <= SEARCH;
                good_q  <= '0;
                bad_q   <= 1'b0;
                locked  <= 1'b0;
            end else begin
                case (state_q)
                    SEARCH: begin
                        if (fs_c) begin
                            state_q <= TRAIN;
                            good_q  <= '0;
                        end
                    end
                    TRAIN: begin
                        if (fs_c) begin
                            if (bad_q | line_err_c | frame_err_c) begin
                                good_q <= '0;
                            end else begin
                                good_q <= good_q + GW'(1);
                                if ((good_q + GW'(1)) == GW'(LOCK_FRAMES)) begin
                                    state_q <= LOCKED;
                                    locked  <= 1'b1;
                                end
                            end
                        end
                    end
                    LOCKED: begin
                        if (line_err_c | frame_err_c) begin
                            state_q <= TRAIN;
                            good_q  <= '0;
                            locked  <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= SEARCH;
                        good_q  <= '0;
                        locked  <= 1'b0;
                    end
                endcase
                // Errors on the frame-start sample belong to the frame just ending.
                if (fs_c) begin
                    bad_q <= 1'b0;
                end else if (line_err_c | frame_err_c) begin
                    bad_q <= 1'b1;
                end
            end
        end
    end

    // Registered coordinates, window flag and one-clk event pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x           <= '0;
            y           <= '0;
            active      <= 1'b0;
            frame_start <= 1'b0;
            line_err    <= 1'b0;
            frame_err   <= 1'b0;
        end else if (pix_en) begin
            frame_start <= fs_c;
            line_err    <= line_err_c;
            frame_err   <= frame_err_c;
            if (in_h_c) begin
                x <= hcnt_d - CW'(H_OFF);
            end
            if (in_v_c) begin
                y <= vcnt_d - CW'(V_OFF);
            end
            // Lock changes only on samples with hcnt=0 or past the window, so the
            // current locked flag gives the same result as the updated one.
            active <= locked & in_h_c & in_v_c;
        end else begin
            frame_start <= 1'b0;
            line_err    <= 1'b0;
            frame_err   <= 1'b0;
        end
    end

`ifdef VGA_DECODER_STATS_EN
    logic [16:0] err_sum_c;

    assign err_sum_c = 17'(err_count) + 17'(line_err_c) + 17'(frame_err_c);

    // Saturating count of line and frame error pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_count <= '0;
        end else if (pix_en) begin
            err_count <= err_sum_c[16] ? 16'hFFFF : err_sum_c[15:0];
        end
    end
`endif

endmodule
